// File: rtl/chunked_adder.sv
// rtl/chunked_adder.sv - multi-cycle chunked adder/subtractor with valid/ready handshakes
//
// Adds two WIDTH-bit operands CHUNK bits per clock, least significant chunk
// first. The carry between chunks is held in a register, so the result is
// bit-exact to a full WIDTH-bit ripple add. Subtraction is a + ~b + 1.
// Operands are latched on the input handshake. The result is held until the
// output handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operands a/b/cin/sub present
//   in_ready   block accepts operands (IDLE only, forced low during rst)
//   a, b       WIDTH-bit operands
//   cin        carry-in, add mode only
//   sub        0: a+b+cin, 1: a-b
//   out_valid  sum/cout/ovf valid
//   out_ready  consumer takes the result
//   sum        WIDTH-bit result modulo 2^WIDTH
//   cout       carry out of MSB (sub mode: 1 = no borrow)
//   ovf        signed overflow

module chunked_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCH   = WIDTH / CHUNK;
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Operand shift registers. The chunk being processed is always in the low
  // CHUNK bits, so no variable part-select is needed.
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [IDX_W-1:0] idx;

  logic             accept;
  logic             last_chunk;
  logic [CHUNK:0]   chunk_full;
  logic [CHUNK-1:0] chunk_sum;
  logic             chunk_cout;
  logic             chunk_ovf;
  logic [WIDTH-1:0] sum_shifted;

  assign in_ready   = (state == IDLE) && !rst;
  assign out_valid  = (state == DONE);
  assign accept     = in_valid && in_ready;
  assign last_chunk = (idx == LAST_IDX);

  assign chunk_full = {1'b0, a_sh[CHUNK-1:0]}
                    + {1'b0, b_sh[CHUNK-1:0]}
                    + {{CHUNK{1'b0}}, carry};
  assign chunk_sum  = chunk_full[CHUNK-1:0];
  assign chunk_cout = chunk_full[CHUNK];

  // On the last chunk the low bits of a_sh/b_sh carry the operand MSBs.
  // Equal operand signs that differ from the result sign are the same
  // condition as carry-into-MSB xor carry-out-of-MSB.
  assign chunk_ovf  = (a_sh[CHUNK-1] == b_sh[CHUNK-1]) &&
                      (chunk_sum[CHUNK-1] != a_sh[CHUNK-1]);

  // The result fills from the top. After NCH shifts, chunk 0 is at the bottom.
  assign sum_shifted = (sum >> CHUNK) | (WIDTH'(chunk_sum) << (WIDTH - CHUNK));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)     state_nxt = RUN;
      RUN:     if (last_chunk) state_nxt = DONE;
      DONE:    if (out_ready)  state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_sh  <= a;
            b_sh  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            idx   <= '0;
          end
        end
        RUN: begin
          sum   <= sum_shifted;
          carry <= chunk_cout;
          a_sh  <= a_sh >> CHUNK;
          b_sh  <= b_sh >> CHUNK;
          idx   <= idx + 1'b1;
          if (last_chunk) begin
            cout <= chunk_cout;
            ovf  <= chunk_ovf;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_adder.sv
// tb/tb_chunked_adder.sv - self-checking bench for chunked_adder (C4, C16, C1 instances)

module tb_chunked_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic [15:0] a_s       [3];
  logic [15:0] b_s       [3];
  logic        cin_s     [3];
  logic        sub_s     [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic [15:0] sum_s     [3];
  logic        cout_s    [3];
  logic        ovf_s     [3];

  int n_total = 0;
  int n_pass  = 0;
  int nch [3] = '{4, 1, 16};

  always #5 clk = ~clk;

  chunked_adder #(.WIDTH(16), .CHUNK(4)) u_c4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a_s[0]), .b(b_s[0]), .cin(cin_s[0]), .sub(sub_s[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .sum(sum_s[0]), .cout(cout_s[0]), .ovf(ovf_s[0]));

  chunked_adder #(.WIDTH(16), .CHUNK(16)) u_c16 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a_s[1]), .b(b_s[1]), .cin(cin_s[1]), .sub(sub_s[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .sum(sum_s[1]), .cout(cout_s[1]), .ovf(ovf_s[1]));

  chunked_adder #(.WIDTH(16), .CHUNK(1)) u_c1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a_s[2]), .b(b_s[2]), .cin(cin_s[2]), .sub(sub_s[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .sum(sum_s[2]), .cout(cout_s[2]), .ovf(ovf_s[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                input logic c, input logic s,
                                output logic [15:0] es, output logic ec, output logic eo);
    int ua, ub, sa, sb, r, sr;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (s) begin
      r  = ua - ub;
      ec = (ua >= ub);
      sr = sa - sb;
    end else begin
      r  = ua + ub + int'(c);
      ec = (r > 65535);
      sr = sa + sb + int'(c);
    end
    es = 16'(r);
    eo = (sr > 32767) || (sr < -32768);
  endfunction

  // Called just after a rising edge. Runs one operation and checks latency, result and handshake.
  task automatic run_op(input int k, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic s, input int bp,
                        output logic [15:0] rs, output logic rc, output logic ro);
    logic [15:0] es;
    logic ec, eo;
    int lat;
    model(a, b, c, s, es, ec, eo);
    chk($sformatf("in_ready_idle[%0d]", k), 32'(in_ready[k]), 32'd1);
    a_s[k] = a; b_s[k] = b; cin_s[k] = c; sub_s[k] = s;
    in_valid[k]  = 1'b1;
    out_ready[k] = 1'b0;
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    a_s[k] = 16'($urandom); b_s[k] = 16'($urandom);
    cin_s[k] = 1'($urandom); sub_s[k] = 1'($urandom);
    lat = 0;
    while (!out_valid[k] && lat < 40) begin
      // Driving out_ready while out_valid is low must have no effect.
      out_ready[k] = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    out_ready[k] = 1'b0;
    chk($sformatf("latency[%0d]", k), 32'(lat), 32'(nch[k]));
    repeat (bp) @(posedge clk);
    #1;
    chk($sformatf("out_valid[%0d]", k), 32'(out_valid[k]), 32'd1);
    chk($sformatf("in_ready_busy[%0d]", k), 32'(in_ready[k]), 32'd0);
    chk($sformatf("sum[%0d] %h%s%h", k, a, s ? "-" : "+", b), 32'(sum_s[k]), 32'(es));
    chk($sformatf("cout[%0d]", k), 32'(cout_s[k]), 32'(ec));
    chk($sformatf("ovf[%0d]", k), 32'(ovf_s[k]), 32'(eo));
    rs = sum_s[k]; rc = cout_s[k]; ro = ovf_s[k];
    out_ready[k] = 1'b1;
    @(posedge clk); #1;
    out_ready[k] = 1'b0;
    chk($sformatf("out_valid_drop[%0d]", k), 32'(out_valid[k]), 32'd0);
    chk($sformatf("sum_hold[%0d]", k), 32'(sum_s[k]), 32'(es));
  endtask

  initial begin
    logic [15:0] rs;
    logic rc, ro;
    int lat;
    int seen;
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b0; out_ready[i] = 1'b0;
      a_s[i] = '0; b_s[i] = '0; cin_s[i] = 1'b0; sub_s[i] = 1'b0;
    end

    // Reset state
    #12;
    chk("rst_in_ready", 32'(in_ready[0]), 32'd0);
    chk("rst_out_valid", 32'(out_valid[0]), 32'd0);
    chk("rst_sum", 32'(sum_s[0]), 32'd0);
    chk("rst_cout_ovf", {30'd0, cout_s[0], ovf_s[0]}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 32'(in_ready[0]), 32'd1);

    // Directed C4 cases
    run_op(0, 16'h1234, 16'h1111, 1'b0, 1'b0, 0, rs, rc, ro);
    chk("t1_sum", 32'(rs), 32'h2345);
    chk("t1_flags", {30'd0, rc, ro}, 32'd0);
    run_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1, rs, rc, ro);
    chk("t2a_sum", 32'(rs), 32'h0000);
    chk("t2a_flags", {30'd0, rc, ro}, 32'b10);
    run_op(0, 16'h00FF, 16'h0000, 1'b1, 1'b0, 0, rs, rc, ro);
    chk("t2b_sum", 32'(rs), 32'h0100);
    run_op(0, 16'h8000, 16'h0001, 1'b1, 1'b1, 0, rs, rc, ro);
    chk("t3a_sum", 32'(rs), 32'h7FFF);
    chk("t3a_flags", {30'd0, rc, ro}, 32'b11);
    run_op(0, 16'h0000, 16'h0001, 1'b0, 1'b1, 2, rs, rc, ro);
    chk("t3b_sum", 32'(rs), 32'hFFFF);
    chk("t3b_flags", {30'd0, rc, ro}, 32'b00);

    // Backpressure: held result, no new acceptance
    a_s[0] = 16'h1234; b_s[0] = 16'h4321; cin_s[0] = 1'b0; sub_s[0] = 1'b0;
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    lat = 0;
    while (!out_valid[0] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_latency", 32'(lat), 32'd4);
    for (int i = 0; i < 10; i++) begin
      chk("bp_out_valid", 32'(out_valid[0]), 32'd1);
      chk("bp_sum", 32'(sum_s[0]), 32'h5555);
      chk("bp_in_ready", 32'(in_ready[0]), 32'd0);
      in_valid[0] = 1'(i & 1);
      a_s[0] = 16'($urandom); b_s[0] = 16'($urandom);
      @(posedge clk); #1;
    end
    in_valid[0] = 1'b0;
    chk("bp_sum_end", 32'(sum_s[0]), 32'h5555);
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    seen = 0;
    repeat (6) begin
      seen += int'(out_valid[0]);
      @(posedge clk); #1;
    end
    chk("bp_no_ghost_op", 32'(seen), 32'd0);

    // Reset after two RUN cycles
    a_s[0] = 16'hAAAA; b_s[0] = 16'h5555;
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrun_rst_in_ready", 32'(in_ready[0]), 32'd0);
    chk("midrun_rst_out_valid", 32'(out_valid[0]), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("after_rst_in_ready", 32'(in_ready[0]), 32'd1);
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      seen += int'(out_valid[0]);
    end
    chk("after_rst_no_valid", 32'(seen), 32'd0);
    run_op(0, 16'h0003, 16'h0004, 1'b0, 1'b0, 0, rs, rc, ro);
    chk("t5_sum", 32'(rs), 32'h0007);

    // Full-width chunk
    run_op(1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, rs, rc, ro);
    chk("t6_sum", 32'(rs), 32'h8000);
    chk("t6_flags", {30'd0, rc, ro}, 32'b01);

    // Randomized ops on every instance against the model
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 15; n++) begin
        run_op(k, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
               int'($urandom_range(0, 3)), rs, rc, ro);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
